// File: rtl/apb_master_mc.sv
// ---------------------------------------------------------------------------
// apb_master_mc
//
// Multi-slave APB4 master. It takes one transfer at a time from a valid/ready
// command port and picks the target slave from the top SEL_W address bits.
// It then runs the APB SETUP/ACCESS sequence on a one-hot PSEL bus. The
// result goes back on a valid/ready response port: read data, slave error,
// address-decode error or wait-state timeout.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cmd_*           command port (valid/ready), address, direction, data, strobes
//   rsp_*           response port (valid/ready), read data, error, timeout flag
//   psel, penable,
//   pwrite, paddr,
//   pwdata, pstrb   APB request outputs (psel one-hot over NUM_SLV slaves)
//   pready,
//   pslverr, prdata per-slave APB inputs; slave i read data is at
//                   prdata[i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module apb_master_mc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic                      cmd_write,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    input  logic [NUM_SLV*DATA_W-1:0] prdata
);

    localparam int STRB_W = DATA_W / 8;
    // The counter only has to reach TIMEOUT-1. A disabled timeout still gets
    // a 1-bit counter so the declarations stay legal.
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [SEL_W-1:0]    idx_q;
    logic [CNT_W-1:0]    wait_cnt;

    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                timeout_q;

    logic [SEL_W-1:0]    cmd_idx;
    logic                cmd_idx_ok;
    logic                sel_pready;
    logic                sel_pslverr;
    logic [DATA_W-1:0]   sel_prdata;
    logic                timeout_hit;

    // Decode the target slave from the address MSBs of the incoming command.
    // An index with no slave behind it becomes a decode error.
    assign cmd_idx    = cmd_addr[ADDR_W-1 -: SEL_W];
    assign cmd_idx_ok = (32'(cmd_idx) < 32'(NUM_SLV));

    // Pick out only the addressed slave's handshake, error and data. The
    // other slaves may drive anything and it never reaches the FSM.
    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_pready  = pready[i];
                sel_pslverr = pslverr[i];
                sel_prdata  = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A timeout fires on the TIMEOUT-th ACCESS cycle if the slave is still
    // not ready. If pready arrives on that same cycle, pready takes priority.
    assign timeout_hit = (TIMEOUT != 0) && !sel_pready && (wait_cnt == CNT_LAST);

    // State register. Reset is synchronous and drops any transfer in flight,
    // including a response that has not been consumed yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. This covers one command from acceptance to response
    // handshake. No second command is buffered.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    next_state = cmd_idx_ok ? SETUP : RESP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (sel_pready || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. The command is latched on acceptance, and the wait
    // counter clears at that point, which is the entry to SETUP. The response
    // fields are written once: on decode error, on slave completion or on
    // timeout. They then stay unchanged for as long as RESP lasts.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            idx_q     <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        write_q   <= cmd_write;
                        wdata_q   <= cmd_wdata;
                        strb_q    <= cmd_write ? cmd_strb : '0;
                        idx_q     <= cmd_idx;
                        wait_cnt  <= '0;
                        rdata_q   <= '0;
                        err_q     <= !cmd_idx_ok;
                        timeout_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (sel_pready) begin
                        err_q     <= sel_pslverr;
                        timeout_q <= 1'b0;
                        rdata_q   <= (!write_q && !sel_pslverr) ? sel_prdata : '0;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. The APB request is driven only in SETUP and ACCESS and
    // is all zeros elsewhere. The response fields are only visible while
    // rsp_valid is high.
    always_comb begin
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        rsp_timeout = 1'b0;
        psel        = '0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        pstrb       = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            SETUP, ACCESS: begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    psel[i] = (idx_q == SEL_W'(i));
                end
                penable = (state == ACCESS);
                pwrite  = write_q;
                paddr   = addr_q;
                pwdata  = wdata_q;
                pstrb   = strb_q;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = rdata_q;
                rsp_err     = err_q;
                rsp_timeout = timeout_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_mc.sv
// ---------------------------------------------------------------------------
// tb_apb_master_mc
//
// Self-checking bench for apb_master_mc with the default parameters (3
// slaves, 2 select bits, TIMEOUT 16). A driver task runs one transfer. It
// plays the addressed slave, with a chosen number of wait states, its error
// and its read data, and fills the other slaves with random values. It
// records what the master did. Each test task then compares those records
// against values derived from the transfer rules.
// ---------------------------------------------------------------------------
module tb_apb_master_mc;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 3;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_W-1:0]         cmd_addr;
    logic                      cmd_write;
    logic [DATA_W-1:0]         cmd_wdata;
    logic [DATA_W/8-1:0]       cmd_strb;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W/8-1:0]       pstrb;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;
    logic [NUM_SLV*DATA_W-1:0] prdata;

    int total = 0;
    int bad   = 0;

    // Records from the most recent transfer.
    int          obs_lat;
    int          obs_setup;
    int          obs_access;
    int          obs_unstable;
    int          obs_busy_ready;
    int          obs_apb_stray;
    int          obs_rsp_change;
    int          obs_rsp_cycles;
    logic        obs_ready_before;
    logic        obs_ready_after;
    logic        obs_hung;
    logic [2:0]  obs_psel;
    logic [31:0] obs_paddr;
    logic        obs_pwrite;
    logic [31:0] obs_pwdata;
    logic [3:0]  obs_pstrb;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_to;

    apb_master_mc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_SLV(NUM_SLV),
        .SEL_W  (SEL_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    always #5 clk = ~clk;

    // Drive the slave inputs for one cycle. The addressed slave gets its
    // planned values. Every other slave gets random noise.
    task automatic drive_slaves(input int idx, input logic rdy, input logic serr,
                                input logic [31:0] sdata);
        for (int i = 0; i < NUM_SLV; i++) begin
            if (i == idx) begin
                pready[i]                  = rdy;
                pslverr[i]                 = serr;
                prdata[i*DATA_W +: DATA_W] = sdata;
            end else begin
                pready[i]                  = 1'($urandom);
                pslverr[i]                 = 1'($urandom);
                prdata[i*DATA_W +: DATA_W] = $urandom;
            end
        end
    endtask

    // Run one command to completion and record the master's behaviour.
    // waits < 0 means the addressed slave never raises pready. hold is the
    // number of extra cycles rsp_ready stays low after rsp_valid appears.
    task automatic do_transfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] s, input int waits, input logic serr,
                               input logic [31:0] sdata, input int hold);
        int   idx;
        int   c;
        bit   done;
        bit   first_apb;
        logic rdy;
        idx = int'(a[31:30]);
        obs_lat = 0; obs_setup = 0; obs_access = 0; obs_unstable = 0;
        obs_busy_ready = 0; obs_apb_stray = 0; obs_rsp_change = 0; obs_rsp_cycles = 0;
        obs_ready_after = 1'b0; obs_hung = 1'b0; obs_psel = '0; obs_paddr = '0;
        obs_pwrite = 1'b0; obs_pwdata = '0; obs_pstrb = '0;
        obs_rdata = '0; obs_err = 1'b0; obs_to = 1'b0;
        first_apb = 1'b1;
        @(negedge clk);
        obs_ready_before = cmd_ready;
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s;
        rsp_ready = 1'b0;
        drive_slaves(idx, 1'b0, serr, sdata);
        c    = 0;
        done = 1'b0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_write = 1'($urandom);
            cmd_wdata = $urandom; cmd_strb = 4'($urandom);
            if (rsp_valid) begin
                obs_lat = c; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
                for (int h = 0; h <= hold; h++) begin
                    if (h > 0) begin
                        @(negedge clk);
                        if (!rsp_valid || rsp_rdata !== obs_rdata || rsp_err !== obs_err ||
                            rsp_timeout !== obs_to) obs_rsp_change++;
                    end
                    obs_rsp_cycles++;
                    if (cmd_ready !== 1'b0) obs_busy_ready++;
                    if (psel != 0 || penable || pwrite || paddr != 0 || pwdata != 0 || pstrb != 0)
                        obs_apb_stray++;
                    rsp_ready = (h == hold);
                    drive_slaves(idx, 1'($urandom), 1'($urandom), $urandom);
                end
                @(negedge clk);
                obs_ready_after = cmd_ready;
                rsp_ready = 1'b0;
                done = 1'b1;
            end else begin
                if (cmd_ready !== 1'b0) obs_busy_ready++;
                rdy = 1'b0;
                if (psel != 0) begin
                    if (!penable) obs_setup++;
                    else obs_access++;
                    if (first_apb) begin
                        obs_psel = psel; obs_paddr = paddr; obs_pwrite = pwrite;
                        obs_pwdata = pwdata; obs_pstrb = pstrb;
                        first_apb = 1'b0;
                    end else if (psel !== obs_psel || paddr !== obs_paddr || pwrite !== obs_pwrite ||
                                 pwdata !== obs_pwdata || pstrb !== obs_pstrb) begin
                        obs_unstable++;
                    end
                    rdy = penable && waits >= 0 && obs_access > waits;
                end else if (penable || pwrite || paddr != 0 || pwdata != 0 || pstrb != 0) begin
                    obs_apb_stray++;
                end
                drive_slaves(idx, rdy, serr, sdata);
            end
        end
        if (!done) obs_hung = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({psel, penable, pwrite} !== 5'b0) begin bad++; $display("[TB] FAIL reset_apb_ctrl got=%b exp=0", {psel, penable, pwrite}); end
        total++; if ({paddr, pwdata, pstrb} !== 68'b0) begin bad++; $display("[TB] FAIL reset_apb_data got=%h exp=0", {paddr, pwdata, pstrb}); end
        total++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'b0) begin bad++; $display("[TB] FAIL reset_rsp_fields got=%h exp=0", {rsp_rdata, rsp_err, rsp_timeout}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write();
        do_transfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'hAAAA_5555, 0);
        total++; if (obs_psel !== 3'b001) begin bad++; $display("[TB] FAIL write_psel got=%b exp=001", obs_psel); end
        total++; if (obs_setup != 1 || obs_access != 1) begin bad++; $display("[TB] FAIL write_phases got=%0d/%0d exp=1/1", obs_setup, obs_access); end
        total++; if (obs_pwdata !== 32'hDEAD_BEEF || obs_pstrb !== 4'hF || obs_pwrite !== 1'b1) begin bad++; $display("[TB] FAIL write_apb got=%h/%h/%b exp=deadbeef/f/1", obs_pwdata, obs_pstrb, obs_pwrite); end
        total++; if (obs_paddr !== 32'h0000_0010) begin bad++; $display("[TB] FAIL write_paddr got=%h exp=00000010", obs_paddr); end
        total++; if (obs_lat != 3) begin bad++; $display("[TB] FAIL write_latency got=%0d exp=3", obs_lat); end
        total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin bad++; $display("[TB] FAIL write_rsp got=%b/%h exp=0/0", obs_err, obs_rdata); end
        total++; if (obs_ready_after !== 1'b1) begin bad++; $display("[TB] FAIL write_ready_after got=%b exp=1", obs_ready_after); end
    endtask

    task automatic test_read_wait();
        do_transfer(32'h4000_0004, 1'b0, 32'h1111_2222, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
        total++; if (obs_psel !== 3'b010) begin bad++; $display("[TB] FAIL read_psel got=%b exp=010", obs_psel); end
        total++; if (obs_pstrb !== 4'h0 || obs_pwrite !== 1'b0) begin bad++; $display("[TB] FAIL read_pstrb got=%h/%b exp=0/0", obs_pstrb, obs_pwrite); end
        total++; if (obs_access != 4) begin bad++; $display("[TB] FAIL read_access_len got=%0d exp=4", obs_access); end
        total++; if (obs_lat != 6) begin bad++; $display("[TB] FAIL read_latency got=%0d exp=6", obs_lat); end
        total++; if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin bad++; $display("[TB] FAIL read_rdata got=%h/%b exp=12345678/0", obs_rdata, obs_err); end
        total++; if (obs_unstable != 0) begin bad++; $display("[TB] FAIL read_stable got=%0d exp=0", obs_unstable); end
    endtask

    task automatic test_decode_err();
        do_transfer(32'hC000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h5A5A_5A5A, 0);
        total++; if (obs_psel !== 3'b000 || obs_setup != 0) begin bad++; $display("[TB] FAIL decode_psel got=%b/%0d exp=000/0", obs_psel, obs_setup); end
        total++; if (obs_lat != 1) begin bad++; $display("[TB] FAIL decode_latency got=%0d exp=1", obs_lat); end
        total++; if ({obs_err, obs_to} !== 2'b10 || obs_rdata !== 32'h0) begin bad++; $display("[TB] FAIL decode_rsp got=%b%b/%h exp=10/0", obs_err, obs_to, obs_rdata); end
        total++; if (obs_apb_stray != 0) begin bad++; $display("[TB] FAIL decode_apb_idle got=%0d exp=0", obs_apb_stray); end
    endtask

    task automatic test_timeout();
        do_transfer(32'h8000_0100, 1'b0, 32'h0, 4'h0, -1, 1'b0, 32'hCAFE_0001, 0);
        total++; if (obs_access != TIMEOUT) begin bad++; $display("[TB] FAIL timeout_access_len got=%0d exp=%0d", obs_access, TIMEOUT); end
        total++; if ({obs_err, obs_to} !== 2'b11 || obs_rdata !== 32'h0) begin bad++; $display("[TB] FAIL timeout_rsp got=%b%b/%h exp=11/0", obs_err, obs_to, obs_rdata); end
        total++; if (obs_lat != TIMEOUT + 2) begin bad++; $display("[TB] FAIL timeout_latency got=%0d exp=%0d", obs_lat, TIMEOUT + 2); end
        do_transfer(32'h8000_0104, 1'b0, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_0002, 0);
        total++; if (obs_access != TIMEOUT) begin bad++; $display("[TB] FAIL late_ready_access_len got=%0d exp=%0d", obs_access, TIMEOUT); end
        total++; if ({obs_err, obs_to} !== 2'b00 || obs_rdata !== 32'hCAFE_0002) begin bad++; $display("[TB] FAIL late_ready_rsp got=%b%b/%h exp=00/cafe0002", obs_err, obs_to, obs_rdata); end
    endtask

    task automatic test_slverr_stall();
        do_transfer(32'h4000_0040, 1'b0, 32'h0, 4'h0, 1, 1'b1, 32'hFFFF_0000, 5);
        total++; if ({obs_err, obs_to} !== 2'b10 || obs_rdata !== 32'h0) begin bad++; $display("[TB] FAIL slverr_rsp got=%b%b/%h exp=10/0", obs_err, obs_to, obs_rdata); end
        total++; if (obs_rsp_cycles != 6 || obs_rsp_change != 0) begin bad++; $display("[TB] FAIL slverr_stable got=%0d/%0d exp=6/0", obs_rsp_cycles, obs_rsp_change); end
        total++; if (obs_busy_ready != 0) begin bad++; $display("[TB] FAIL slverr_cmd_ready got=%0d exp=0", obs_busy_ready); end
        total++; if (obs_apb_stray != 0) begin bad++; $display("[TB] FAIL slverr_apb_in_resp got=%0d exp=0", obs_apb_stray); end
    endtask

    task automatic test_reset_mid();
        int c;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h8000_0020; cmd_write = 1'b1;
        cmd_wdata = 32'h0BAD_F00D; cmd_strb = 4'h3;
        drive_slaves(2, 1'b0, 1'b0, 32'h0);
        c = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            drive_slaves(2, 1'b0, 1'b0, 32'h0);
            c++;
        end while (!(psel != 0 && penable) && c < 20);
        total++; if (c >= 20) begin bad++; $display("[TB] FAIL rstmid_reach_access got=%0d exp=<20", c); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({psel, penable, pwrite} !== 5'b0 || {paddr, pwdata, pstrb} !== 68'b0) begin bad++; $display("[TB] FAIL rstmid_apb got=%b/%h exp=0/0", {psel, penable, pwrite}, {paddr, pwdata, pstrb}); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); end
        rst = 1'b0;
        drive_slaves(2, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_discard got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
    endtask

    // Random transfers. Expected values come from the transfer rules alone:
    // the decode range, ACCESS length from wait states capped by TIMEOUT,
    // the error/data priority, and the fixed setup and response latencies.
    task automatic test_random();
        logic [31:0] a, d, sd;
        logic [3:0]  s;
        logic        w, se, valid, timed;
        int          waits, hold, idx, exp_acc, exp_lat;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_psel;
        for (int n = 0; n < 40; n++) begin
            a  = $urandom; d = $urandom; sd = $urandom; s = 4'($urandom);
            w  = 1'($urandom); se = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       waits = -1;
                1:       waits = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
                default: waits = $urandom_range(0, 5);
            endcase
            hold = $urandom_range(0, 2);
            idx  = int'(a[31:30]);
            do_transfer(a, w, d, s, waits, se, sd, hold);
            valid     = (idx < NUM_SLV);
            timed     = valid && (waits < 0 || waits >= TIMEOUT);
            exp_acc   = !valid ? 0 : (timed ? TIMEOUT : waits + 1);
            exp_lat   = !valid ? 1 : 2 + exp_acc;
            exp_psel  = valid ? 3'(1 << idx) : 3'b000;
            exp_rdata = (valid && !timed && !w && !se) ? sd : 32'h0;
            total++; if (obs_hung) begin bad++; $display("[TB] FAIL rnd%0d_hang got=no_rsp exp=rsp", n); end
            total++; if (obs_ready_before !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_ready_before got=%b exp=1", n, obs_ready_before); end
            total++; if (obs_lat != exp_lat) begin bad++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", n, obs_lat, exp_lat); end
            total++; if (obs_psel !== exp_psel) begin bad++; $display("[TB] FAIL rnd%0d_psel got=%b exp=%b", n, obs_psel, exp_psel); end
            total++; if (obs_setup != (valid ? 1 : 0) || obs_access != exp_acc) begin bad++; $display("[TB] FAIL rnd%0d_phases got=%0d/%0d exp=%0d/%0d", n, obs_setup, obs_access, valid ? 1 : 0, exp_acc); end
            if (valid) begin
                total++; if (obs_paddr !== a || obs_pwrite !== w || obs_pwdata !== d || obs_pstrb !== (w ? s : 4'h0)) begin bad++; $display("[TB] FAIL rnd%0d_apb got=%h/%b/%h/%h exp=%h/%b/%h/%h", n, obs_paddr, obs_pwrite, obs_pwdata, obs_pstrb, a, w, d, w ? s : 4'h0); end
            end
            total++; if (obs_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rnd%0d_rdata got=%h exp=%h", n, obs_rdata, exp_rdata); end
            total++; if (obs_err !== (!valid || timed || se) || obs_to !== timed) begin bad++; $display("[TB] FAIL rnd%0d_err got=%b%b exp=%b%b", n, obs_err, obs_to, !valid || timed || se, timed); end
            total++; if (obs_unstable != 0 || obs_apb_stray != 0 || obs_rsp_change != 0 || obs_busy_ready != 0) begin bad++; $display("[TB] FAIL rnd%0d_protocol got=%0d/%0d/%0d/%0d exp=0/0/0/0", n, obs_unstable, obs_apb_stray, obs_rsp_change, obs_busy_ready); end
            total++; if (obs_ready_after !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_ready_after got=%b exp=1", n, obs_ready_after); end
        end
    endtask

    initial begin
        $display("[TB] apb_master_mc bench start");
        test_reset();
        test_write();
        test_read_wait();
        test_decode_err();
        test_timeout();
        test_slverr_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_mc.md
# apb_master_mc

Parametrised, multi-slave APB4 master. It accepts single transfer commands on a valid/ready command port, decodes the target slave from the upper address bits, and runs the APB SETUP/ACCESS sequence on a one-hot PSEL bus. It returns read data, PSLVERR, decode errors and wait-state timeouts on a valid/ready response port. It replaces the fixed 32-bit single-slave master between the system command logic and the APB slave fabric.

## Interface

- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8.
- NUM_SLV, 3: number of slaves, must be ≤ 2**SEL_W.
- SEL_W, 2: address bits used for slave decode, taken from the address MSBs.
- TIMEOUT, 16: maximum ACCESS cycles per transfer; 0 disables the timeout.
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  PSLVERR, decode error, or timeout.
- rsp_timeout  out  1  transfer ended by timeout.
- psel  out  NUM_SLV  one-hot slave select.
- penable, pwrite  out  1  APB enable and direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes; forced to 0 on reads.
- pready, pslverr  in  NUM_SLV  per-slave ready and error.
- prdata  in  NUM_SLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].

## Operation

- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register addr, write, wdata and strb, and compute idx = cmd_addr[ADDR_W-1 -: SEL_W].
  - If idx < NUM_SLV, go to SETUP. Otherwise go to RESP with rsp_err = 1, rsp_timeout = 0, and rsp_rdata = 0; no PSEL is driven.
- SETUP:
  - psel[idx] = 1, penable = 0, and paddr/pwrite/pwdata/pstrb are driven from the registers.
  - Always moves to ACCESS after one cycle.
- ACCESS:
  - psel[idx] = 1 and penable = 1; the address and control signals stay stable.
  - On pready[idx] = 1:
    - capture pslverr[idx] into rsp_err;
    - capture prdata slice idx into rsp_rdata if the transfer is a read and pslverr is 0, otherwise 0;
    - go to RESP.
  - Otherwise, increment the wait counter. When TIMEOUT ≠ 0 and the counter reaches TIMEOUT with pready still low, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready is high on the TIMEOUT-th cycle, pready wins and there is no timeout.
- RESP:
  - rsp_valid = 1 with stable response fields; all APB outputs are 0.
  - On rsp_ready, go to IDLE.
- Only the selected slave's pready, pslverr and prdata are observed; the other slaves' inputs are ignored.
- In every state other than SETUP and ACCESS, psel, penable, paddr, pwrite, pwdata and pstrb are all 0.
- The wait counter clears on entry to SETUP and is wide enough to hold TIMEOUT.

## Timing

- Reset: on rst = 1 at a clock edge, the state goes to IDLE and every output is 0 except cmd_ready, which is 1 from the first cycle after reset.
- Reset applied mid-transfer drops PSEL/PENABLE on the next edge and discards the pending response.
- Command accepted at edge T, zero wait states:
  - SETUP during cycle T+1;
  - ACCESS during T+2, where pready is sampled;
  - rsp_valid during T+3;
  - with rsp_ready high at T+3, cmd_ready is high again during T+4.
- Throughput is 4 cycles per transfer; each APB wait state adds 1 cycle.
- Decode error: rsp_valid is asserted in the cycle after acceptance, a 1-cycle latency.
- Timeout: rsp_valid follows TIMEOUT ACCESS cycles with pready low.
- rsp_valid held with rsp_ready low: the block stalls in RESP indefinitely, all fields stay stable, and cmd_ready = 0.
- cmd_ready is 0 in SETUP, ACCESS and RESP; no command is buffered.

## Test plan

- Write: addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, slave 0 pready = 1 immediately -> psel = 3'b001 for 2 cycles, penable only in the second, pwdata = 0xDEAD_BEEF, pstrb = 0xF; rsp_valid at T+3 with err = 0 and rdata = 0.
- Read: addr 0x4000_0004 to slave 1, 3 wait states, prdata1 = 0x1234_5678 -> pstrb = 0, ACCESS lasts 4 cycles; rsp_rdata = 0x1234_5678 at T+6.
- Read: addr 0xC000_0000 with NUM_SLV = 3 -> psel stays 0; rsp_valid at T+1 with err = 1, timeout = 0, rdata = 0.
- Slave 2 never asserts pready, TIMEOUT = 16 -> ACCESS lasts exactly 16 cycles, then rsp_err = 1 and rsp_timeout = 1; a separate run with pready rising on cycle 16 completes normally.
- PSLVERR on a read; rsp_ready held low for 5 cycles -> rdata = 0, err = 1, response stable for 6 cycles, cmd_ready = 0 throughout. A second run asserts rst during ACCESS -> all APB outputs are 0 and cmd_ready = 1 after the reset edge.
